tinyqv_nibble_ram_responder: RTL and testbench

//  Responder end of the core's nibble-serial load/store port: a small 32-bit-word RAM peripheral.

---
 rtl/tinyqv_nibble_ram_responder_pkg.sv | 30 +++
 rtl/tinyqv_lane_align.sv | 44 ++++
 rtl/tinyqv_nibble_ram_responder.sv | 153 +++++++++++++++
 tb/tb_tinyqv_nibble_ram_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyqv_nibble_ram_responder_pkg.sv
// Shared definitions for the TinyQV nibble-serial load/store responders:
// access-size encodings, responder FSM states and an alignment helper.
package tinyqv_nibble_ram_responder_pkg;

  // mem_op[1:0] access size; mem_op[2] (sign) is handled by the core.
  typedef enum logic [1:0] {
    MEM_OP_BYTE = 2'b00,
    MEM_OP_HALF = 2'b01,
    MEM_OP_WORD = 2'b10,
    MEM_OP_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // True when the access cannot be served: reserved size or an address
  // that is not naturally aligned for the size.
  function automatic logic size_misaligned(input mem_size_e size, input logic [1:0] offset);
    case (size)
      MEM_OP_BYTE: return 1'b0;
      MEM_OP_HALF: return offset[0];
      MEM_OP_WORD: return |offset;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tinyqv_lane_align.sv
// Byte-lane alignment for 32-bit word peripherals on the nibble bus.
// Ports:
//   size_i    access size (byte/half/word)
//   offset_i  byte offset within the word (addr[1:0])
//   wdata_i   store data, right-aligned as delivered by the core
//   rword_i   word read from storage
//   wmask_o   per-byte write enables
//   wdata_o   store data replicated onto the addressed lanes
//   rdata_o   read word shifted right so the addressed byte is at bit 0
module tinyqv_lane_align
  import tinyqv_nibble_ram_responder_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    wmask_o = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      MEM_OP_BYTE: begin
        wmask_o = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_OP_HALF: begin
        wmask_o = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      MEM_OP_WORD: wmask_o = 4'b1111;
      default:     wmask_o = 4'b0000;
    endcase
  end

  // Zero-filled right shift; the core applies sign extension itself.
  assign rdata_o = rword_i >> {offset_i, 3'b000};

endmodule

// File: rtl/tinyqv_nibble_ram_responder.sv
// Small 32-bit-word RAM on the TinyQV nibble-serial load/store port.
// Store nibbles arrive during the address frame and are committed on
// address_ready; load data is returned nibble-serially LATENCY frames later.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   counter           core sub-cycle counter (0..7, wraps)
//   addr_in           byte address, valid with address_ready
//   address_ready     address frame end strobe (only honoured at counter 7)
//   is_load/is_store  access type
//   mem_op            [1:0] size, [2] ignored
//   store_data        store nibble k at counter k of the address frame
//   load_data         load nibble k at counter k of the data frame, else 0
//   load_data_ready   high for counter 0..7 of the data frame
//   busy              load accepted and data frame not finished
//   bus_error         one-clock pulse after a rejected access
module tinyqv_nibble_ram_responder
  import tinyqv_nibble_ram_responder_pkg::*;
#(
  parameter int          WORD_BITS = 5,
  parameter logic [27:0] BASE_ADDR = 28'h800000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  counter,
  input  logic [27:0] addr_in,
  input  logic        address_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  store_data,
  output logic [3:0]  load_data,
  output logic        load_data_ready,
  output logic        busy,
  output logic        bus_error
);

  localparam int         WORDS    = 1 << WORD_BITS;
  localparam int         WIN_LSB  = WORD_BITS + 2;
  localparam logic [2:0] LAT_INIT = 3'(LATENCY);

  state_e      state_q;
  logic [2:0]  lat_q;
  logic [31:0] sbuf_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        err_q;
  logic [31:0] mem_q [WORDS];

  mem_size_e            size;
  logic                 frame_end;
  logic                 commit;
  logic                 access;
  logic                 in_window;
  logic                 reject;
  logic                 accept;
  logic [WORD_BITS-1:0] word_idx;
  logic [31:0]          store_word;
  logic [3:0]           lane_mask;
  logic [31:0]          lane_wdata;
  logic [31:0]          lane_rdata;
  logic                 unused_bits;

  assign unused_bits = mem_op[2];

  assign size      = mem_size_e'(mem_op[1:0]);
  assign frame_end = (counter == 3'd7);
  assign commit    = address_ready && frame_end;
  assign access    = is_load || is_store;
  assign in_window = (addr_in[27:WIN_LSB] == BASE_ADDR[27:WIN_LSB]);
  assign word_idx  = addr_in[WIN_LSB-1:2];

  // The eighth nibble is still on store_data at commit time, so the word is
  // assembled from the live input plus the seven already shifted in.
  assign store_word = {store_data, sbuf_q[31:4]};

  assign reject = commit && access &&
                  (!in_window || size_misaligned(size, addr_in[1:0]) ||
                   (is_load && is_store) || busy_q);
  assign accept = commit && access && !reject;

  tinyqv_lane_align u_align (
    .size_i   (size),
    .offset_i (addr_in[1:0]),
    .wdata_i  (store_word),
    .rword_i  (mem_q[word_idx]),
    .wmask_o  (lane_mask),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  // NOTE: the RAM array has no reset; software must write before reading.
  // The write is suppressed while rst is high so a reset never leaves a
  // partial store behind.
  always_ff @(posedge clk) begin
    if (accept && is_store && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem_q[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= 3'd0;
      sbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (is_store) sbuf_q <= store_word;
      err_q <= reject;
      case (state_q)
        ST_IDLE: begin
          // accept implies !busy_q, i.e. this state.
          if (accept && is_load) begin
            rdata_q <= lane_rdata;
            busy_q  <= 1'b1;
            if (LATENCY == 0) begin
              state_q <= ST_STREAM;
            end else begin
              state_q <= ST_WAIT;
              lat_q   <= LAT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (frame_end) begin
            lat_q <= lat_q - 3'd1;
            if (lat_q == 3'd1) state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (frame_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Decoded from registered state and the core's counter only.
  assign load_data_ready = (state_q == ST_STREAM);
  assign load_data       = load_data_ready ? rdata_q[{counter, 2'b00} +: 4] : 4'h0;
  assign busy            = busy_q;
  assign bus_error       = err_q;

endmodule

// File: tb/tb_tinyqv_nibble_ram_responder.sv
// Drives three responders (LATENCY 0, 1, 7) with the same frames and checks
// every cycle against a byte-addressed reference model.
module tb_tinyqv_nibble_ram_responder;

  localparam logic [27:0] BASE = 28'h800000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  counter = 3'd0;
  logic [27:0] addr_in = 28'd0;
  logic        address_ready = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [3:0]  store_data = 4'd0;
  logic [3:0]  ld  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        err [3];

  always #5 clk = ~clk;

  tinyqv_nibble_ram_responder #(.WORD_BITS(5), .BASE_ADDR(BASE), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .counter(counter), .addr_in(addr_in), .address_ready(address_ready),
    .is_load(is_load), .is_store(is_store), .mem_op(mem_op), .store_data(store_data),
    .load_data(ld[0]), .load_data_ready(rdy[0]), .busy(bsy[0]), .bus_error(err[0]));
  tinyqv_nibble_ram_responder #(.WORD_BITS(5), .BASE_ADDR(BASE), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .counter(counter), .addr_in(addr_in), .address_ready(address_ready),
    .is_load(is_load), .is_store(is_store), .mem_op(mem_op), .store_data(store_data),
    .load_data(ld[1]), .load_data_ready(rdy[1]), .busy(bsy[1]), .bus_error(err[1]));
  tinyqv_nibble_ram_responder #(.WORD_BITS(5), .BASE_ADDR(BASE), .LATENCY(7)) u2 (
    .clk(clk), .rst(rst), .counter(counter), .addr_in(addr_in), .address_ready(address_ready),
    .is_load(is_load), .is_store(is_store), .mem_op(mem_op), .store_data(store_data),
    .load_data(ld[2]), .load_data_ready(rdy[2]), .busy(bsy[2]), .bus_error(err[2]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 7;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  mbytes [3][128];
  logic [31:0] frame_wdata = 32'd0;
  int          fr = 0;
  bit          pend  [3] = '{0, 0, 0};
  int          afr   [3] = '{0, 0, 0};
  int          dfr   [3] = '{0, 0, 0};
  int          errfr [3] = '{-1, -1, -1};
  logic [31:0] mrd   [3] = '{32'd0, 32'd0, 32'd0};

  task automatic model_edge();
    int sz, nb, off;
    bit inwin, badacc;
    logic [31:0] rd;
    if (!(address_ready && counter == 3'd7 && (is_load || is_store))) return;
    sz    = int'(mem_op[1:0]);
    nb    = 1 << sz;
    inwin = (addr_in >= BASE) && (addr_in < BASE + 28'd128);
    off   = int'(addr_in - BASE);
    for (int i = 0; i < 3; i++) begin
      badacc = !inwin || sz == 3 || (off % nb) != 0 || (is_load && is_store) ||
               (pend[i] && fr <= dfr[i]);
      if (badacc) begin
        errfr[i] = fr + 1;
      end else if (is_store) begin
        for (int b = 0; b < nb; b++) mbytes[i][off+b] = frame_wdata[8*b +: 8];
      end else begin
        rd = 32'd0;
        for (int b = 0; (off % 4) + b < 4; b++) rd[8*b +: 8] = mbytes[i][off+b];
        mrd[i]  = rd;
        pend[i] = 1'b1;
        afr[i]  = fr;
        dfr[i]  = fr + 1 + lat_of(i);
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) model_edge();
    if (counter == 3'd7) fr++;
  end

  always @(posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      pend[i]  = 1'b0;
      errfr[i] = -1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit e_rdy, e_bsy, e_err;
      logic [3:0] e_ld;
      e_rdy = pend[i] && fr == dfr[i];
      e_ld  = e_rdy ? mrd[i][4*int'(counter) +: 4] : 4'h0;
      e_bsy = pend[i] && fr > afr[i] && fr <= dfr[i];
      e_err = (errfr[i] == fr) && counter == 3'd0;
      check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(e_rdy));
      check($sformatf("data%0d", i),  32'(ld[i]),  32'(e_ld));
      check($sformatf("busy%0d", i),  32'(bsy[i]), 32'(e_bsy));
      check($sformatf("berr%0d", i),  32'(err[i]), 32'(e_err));
    end
  end

  // Capture of streamed words for the literal expectations.
  logic [31:0] cap   [3];
  int          ncap  [3];
  int          nerr  [3];
  int          nbsy  [3];
  int          first_fr [3];

  task automatic clr_cap();
    for (int i = 0; i < 3; i++) begin
      cap[i] = 32'd0; ncap[i] = 0; nerr[i] = 0; nbsy[i] = 0; first_fr[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] === 1'b1) begin
        cap[i][4*int'(counter) +: 4] = ld[i];
        if (ncap[i] == 0) first_fr[i] = fr;
        ncap[i]++;
      end
      if (err[i] === 1'b1) nerr[i]++;
      if (bsy[i] === 1'b1) nbsy[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(input bit ld_, input bit st_, input logic [1:0] sz, input logic [27:0] a,
                       input logic [31:0] wd, input bit ar7, input int noise_c);
    frame_wdata = wd;
    for (int c = 0; c < 8; c++) begin
      counter       = 3'(c);
      is_load       = ld_;
      is_store      = st_;
      mem_op        = {1'($urandom_range(0, 1)), sz};
      addr_in       = a;
      store_data    = wd[4*c +: 4];
      address_ready = (c == 7) ? ar7 : (c == noise_c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) frame(1'b0, 1'b0, 2'b00, 28'd0, 32'd0, 1'b0, -1);
  endtask

  task automatic rst_frame();
    for (int c = 0; c < 8; c++) begin
      counter = 3'(c); is_load = 1'b0; is_store = 1'b0; address_ready = 1'b0;
      rst = (c == 2 || c == 3);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_words(input string name, input logic [31:0] w);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_word%0d", name, i), cap[i], w);
      check($sformatf("%s_width%0d", name, i), 32'(ncap[i]), 32'd8);
    end
  endtask

  initial begin
    int lf;
    clr_cap();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_busy%0d", i),  32'(bsy[i]), 32'd0);
      check($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("reset_berr%0d", i),  32'(err[i]), 32'd0);
      check($sformatf("reset_data%0d", i),  32'(ld[i]),  32'd0);
    end
    @(posedge clk); #1;
    counter = 3'd1;
    // realign to frame start
    for (int c = 1; c < 8; c++) begin counter = 3'(c); @(posedge clk); #1; end
    idle(1);
    rst = 1'b0;
    idle(1);

    for (int k = 0; k < 32; k++) frame(1'b0, 1'b1, 2'b10, BASE + 28'(4*k), $urandom, 1'b1, -1);

    // word store / word load, latency offsets 1, 2, 8 frames
    frame(1'b0, 1'b1, 2'b10, BASE + 28'h10, 32'hDEADBEEF, 1'b1, -1);
    clr_cap();
    lf = fr;
    frame(1'b1, 1'b0, 2'b10, BASE + 28'h10, 32'd0, 1'b1, -1);
    check("model_pin", mrd[1], 32'hDEADBEEF);
    idle(9);
    expect_words("deadbeef", 32'hDEADBEEF);
    check("lat0_frame", 32'(first_fr[0] - lf), 32'd1);
    check("lat1_frame", 32'(first_fr[1] - lf), 32'd2);
    check("lat7_frame", 32'(first_fr[2] - lf), 32'd8);

    // byte store into an existing word, then word and byte loads
    frame(1'b0, 1'b1, 2'b10, BASE + 28'h10, 32'h11223344, 1'b1, -1);
    frame(1'b0, 1'b1, 2'b00, BASE + 28'h13, 32'h0000005A, 1'b1, -1);
    clr_cap();
    frame(1'b1, 1'b0, 2'b10, BASE + 28'h10, 32'd0, 1'b1, -1);
    idle(9);
    expect_words("byte_merge", 32'h5A223344);
    clr_cap();
    frame(1'b1, 1'b0, 2'b00, BASE + 28'h13, 32'd0, 1'b1, -1);
    idle(9);
    expect_words("byte_load", 32'h0000005A);

    // half store, misaligned half rejected
    frame(1'b0, 1'b1, 2'b10, BASE, 32'h00000000, 1'b1, -1);
    frame(1'b0, 1'b1, 2'b01, BASE + 28'h02, 32'h0000BEEF, 1'b1, -1);
    clr_cap();
    frame(1'b0, 1'b1, 2'b01, BASE + 28'h01, 32'h00001234, 1'b1, -1);
    idle(1);
    for (int i = 0; i < 3; i++) check($sformatf("half_misalign_err%0d", i), 32'(nerr[i]), 32'd1);
    clr_cap();
    frame(1'b1, 1'b0, 2'b10, BASE, 32'd0, 1'b1, -1);
    idle(9);
    expect_words("half_store", 32'hBEEF0000);

    // out-of-window load
    clr_cap();
    frame(1'b1, 1'b0, 2'b10, BASE - 28'd4, 32'd0, 1'b1, -1);
    idle(9);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("oow_err%0d", i),   32'(nerr[i]), 32'd1);
      check($sformatf("oow_ready%0d", i), 32'(ncap[i]), 32'd0);
      check($sformatf("oow_busy%0d", i),  32'(nbsy[i]), 32'd0);
    end

    // reset while waiting: no data frame, next load normal
    clr_cap();
    frame(1'b1, 1'b0, 2'b10, BASE + 28'h10, 32'd0, 1'b1, -1);
    rst_frame();
    idle(9);
    check("rst_wait_ready1", 32'(ncap[1]), 32'd0);
    check("rst_wait_ready2", 32'(ncap[2]), 32'd0);
    clr_cap();
    frame(1'b1, 1'b0, 2'b10, BASE + 28'h10, 32'd0, 1'b1, -1);
    idle(9);
    expect_words("after_rst", 32'h5A223344);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind, asel, noise;
      logic [1:0]  sz;
      logic [27:0] a;
      if ($urandom_range(0, 19) == 0) begin
        rst_frame();
        continue;
      end
      kind  = $urandom_range(0, 9);
      sz    = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      asel  = $urandom_range(0, 9);
      if (asel == 0)      a = 28'($urandom);
      else if (asel == 1) a = BASE - 28'd4;
      else                a = BASE + 28'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      noise = $urandom_range(0, 9);
      frame(kind >= 4 && kind <= 8, kind <= 3 || kind == 8, sz, a, $urandom,
            $urandom_range(0, 9) != 0, noise);
    end
    idle(9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
